// File: rtl/pkt_tx_sched.sv
// pkt_tx_sched: two-requester packet scheduler for the 8b/10b encoder path.
// Frames each packet as K.28.1 sync codes, payload, K.28.5, then a guard gap.
module pkt_tx_sched #(
  parameter int SYNC_CNT  = 4,
  parameter int GUARD_CYC = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  input  logic [7:0]  req_data0,
  input  logic [7:0]  req_data1,
  input  logic [1:0]  req_last,
  output logic [1:0]  req_ready,
  output logic [1:0]  gnt,
  output logic        pushin,
  output logic [7:0]  datain,
  output logic        k,
  output logic        busy,
  output logic [15:0] pkt_cnt
);

  localparam int SW = $clog2(SYNC_CNT + 1);
  localparam int GW = $clog2(GUARD_CYC + 1);

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
    EOP,
    GUARD
  } state_t;

  state_t        state;
  logic          last_gnt;
  logic [SW-1:0] sync_cnt;
  logic [GW-1:0] guard_cnt;
  logic          pick;
  logic          gidx;
  logic          xfer;
  logic [7:0]    sel_data;
  logic          sel_last;

  assign req_ready = (state == DATA) ? gnt : 2'b00;
  assign gidx      = gnt[1];
  assign xfer      = |(req_valid & req_ready);
  assign sel_data  = gidx ? req_data1 : req_data0;
  assign sel_last  = req_last[gidx];

  // On contention, alternate away from the last winner.
  assign pick = (&req_valid) ? ~last_gnt : req_valid[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= 2'b00;
      last_gnt  <= 1'b1;
      pushin    <= 1'b0;
      datain    <= 8'h00;
      k         <= 1'b0;
      busy      <= 1'b0;
      pkt_cnt   <= 16'h0000;
      sync_cnt  <= '0;
      guard_cnt <= '0;
    end else begin
      pushin <= 1'b0;
      datain <= 8'h00;
      k      <= 1'b0;
      case (state)
        IDLE: begin
          if (|req_valid) begin
            gnt      <= pick ? 2'b10 : 2'b01;
            last_gnt <= pick;
            sync_cnt <= '0;
            busy     <= 1'b1;
            state    <= SYNC;
          end
        end
        SYNC: begin
          pushin <= 1'b1;
          datain <= 8'h3C;
          k      <= 1'b1;
          if (sync_cnt == SW'(SYNC_CNT - 1)) begin
            sync_cnt <= '0;
            state    <= DATA;
          end else begin
            sync_cnt <= sync_cnt + 1'b1;
          end
        end
        DATA: begin
          if (xfer) begin
            pushin <= 1'b1;
            datain <= sel_data;
            if (sel_last) state <= EOP;
          end
        end
        EOP: begin
          pushin    <= 1'b1;
          datain    <= 8'hBC;
          k         <= 1'b1;
          pkt_cnt   <= pkt_cnt + 16'd1;
          gnt       <= 2'b00;
          guard_cnt <= '0;
          state     <= GUARD;
        end
        GUARD: begin
          if (guard_cnt == GW'(GUARD_CYC - 1)) begin
            guard_cnt <= '0;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            guard_cnt <= guard_cnt + 1'b1;
          end
        end
        default: begin
          gnt   <= 2'b00;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/pkt_tx_sched.md
PKT_TX_SCHED -- requirements
Module: pkt_tx_sched

Interface
REQ-001 Parameter: SYNC_CNT, 4, number of K.28.1 sync codes sent before each packet payload.
REQ-002 Parameter: GUARD_CYC, 10, number of idle (pushin low) cycles forced after each K.28.5.
REQ-003 Port: clk  input  1  the only clock; all flops are rising-edge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: req_valid  input  2  per-requester byte-valid; index 0 is requester 0, index 1 is requester 1.
REQ-006 Port: req_data0, req_data1  input  8 each  payload byte for requester 0 and requester 1.
REQ-007 Port: req_last  input  2  per-requester flag marking the final payload byte of a packet.
REQ-008 Port: req_ready  output  2  per-requester byte accept; combinational from state and grant only.
REQ-009 Port: gnt  output  2  registered one-hot grant to the requester that owns the encoder; 0 when no requester owns it.
REQ-010 Port: pushin  output  1  registered push strobe to the 8b/10b encoder/CRC datapath.
REQ-011 Port: datain  output  8  registered byte to the encoder.
REQ-012 Port: k  output  1  registered control-code flag to the encoder; 1 means datain is a K code.
REQ-013 Port: busy  output  1  high in every state except IDLE.
REQ-014 Port: pkt_cnt  output  16  count of completed packets (K.28.5 issued); wraps from 0xFFFF to 0.

Function
REQ-015 States: IDLE, SYNC, DATA, EOP, GUARD; all outputs are flop-driven, except req_ready.
REQ-016 Outputs registered: the decision made in cycle c appears on pushin/datain/k in cycle c+1.
REQ-017 IDLE: if any req_valid bit is high, register the grant and go to SYNC; otherwise stay in IDLE with pushin=0.
REQ-018 Arbitration: round-robin at packet boundaries only; if both requesters are valid, grant the one not granted last; a single valid requester always wins.
REQ-019 The last-granted pointer resets to 1, so requester 0 wins the first contention after reset.
REQ-020 SYNC: issue SYNC_CNT consecutive codes with datain=0x3C (K.28.1), k=1, pushin=1, then go to DATA.
REQ-021 DATA: req_ready is high only for the granted index; a transfer occurs when req_valid & req_ready.
REQ-022 Each DATA transfer produces, in the next cycle, pushin=1, k=0, datain=the granted byte.
REQ-023 A DATA cycle with no transfer produces pushin=0 in the next cycle; this stall is legal, and no sync code is reinserted.
REQ-024 Transfer with req_last=1: go to EOP; non-granted req_valid/req_last inputs are ignored in every state.
REQ-025 EOP (one cycle): issue datain=0xBC (K.28.5), k=1, pushin=1; increment pkt_cnt; go to GUARD.
REQ-026 GUARD: hold pushin=0 for exactly GUARD_CYC output cycles after the K.28.5 cycle; gnt clears on GUARD entry; then go to IDLE.
REQ-027 Minimum spacing: at least GUARD_CYC+1 cycles separate a K.28.5 output from the next K.28.1 output, so the downstream CRC/K.23.7 insertion always has its window.
REQ-028 The block never emits 0xF7 (K.23.7) or 0xFC (K.28.7) with k=1; 0xF7 and 0xFC as data (k=0) pass through unchanged.
REQ-029 Whenever pushin=0, datain=0 and k=0.
REQ-030 req_ready is 0 in IDLE, SYNC, EOP and GUARD.

Reset
REQ-031 rst_n low asynchronously forces: state=IDLE, gnt=0, pushin=0, datain=0, k=0, busy=0, pkt_cnt=0, req_ready=0, last-granted=1, and all counters cleared.
REQ-032 Reset mid-packet abandons the packet without a K.28.5; after release, the block restarts from IDLE with no guard period.

Verification
REQ-033 Requester 0 sends a 3-byte packet 0x11,0x22,0x33(last) -> outputs 0x3C/k1 x4, then 0x11,0x22,0x33/k0, then 0xBC/k1, then 10 cycles of pushin=0; pkt_cnt=1.
REQ-034 Both requesters are valid from reset -> gnt=01 for the first packet and gnt=10 for the second; the second packet's first 0x3C appears at least 11 cycles after the first 0xBC.
REQ-035 req_valid drops for 2 cycles mid-payload -> exactly 2 pushin=0 bubbles between data bytes, with no extra 0x3C.
REQ-036 Requester 1 sends a single byte 0xF7 with last -> 0x3C x4, then 0xF7/k0, then 0xBC/k1.
REQ-037 rst_n is asserted during the second data byte -> all outputs are 0 in the same cycle, no 0xBC is emitted, pkt_cnt=0, and the next packet starts normally.
REQ-038 Preload pkt_cnt=0xFFFF and complete one packet -> pkt_cnt=0x0000.
